// File: rtl/game_pkg.sv
// Shared definitions for the game controller, player input and display stages.
// Grid cells are numbered row*GRID_DIM+col, row 0 at the top, col 0 at the left.
package game_pkg;

    localparam logic [1:0] GS_INIT   = 2'b00;
    localparam logic [1:0] GS_PLAY   = 2'b01;
    localparam logic [1:0] GS_FINISH = 2'b10;

    localparam int         GRID_DIM   = 3;
    localparam logic [8:0] BOX_CENTRE = 9'b000010000;

    function automatic logic [8:0] rc_to_box(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] idx;
        idx = 4'(row) * 4'(GRID_DIM) + 4'(col);
        return 9'b1 << idx;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One raw push-button: 2-flop synchronizer, counter debounce, rising-edge one-pulse.
// A level change is accepted only after DB_CYCLES consecutive disagreeing samples.
module btn_conditioner #(
    parameter int DB_CYCLES = 1000000,
    localparam int CNT_W    = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic             r_db_d;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1   <= raw;
            r_s2   <= r_s1;
            r_db_d <= r_db;
            // Any sample matching the accepted level restarts the count, rejecting short glitches.
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_pulse <= r_db & ~r_db_d;
        end
    end

    assign level = r_db;
    assign pulse = r_pulse;

endmodule

// File: rtl/player_input.sv
// Player input stage: conditions five buttons and tracks the player's 3x3 grid position.
// Moves only in PLAY, re-centres in INIT, freezes in FINISH; start_op passes through in every state.
module player_input
    import game_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    input  logic [1:0] game_state,
    output logic [8:0] box,
    output logic       start_op,
    output logic       move_pulse
);

    localparam logic [1:0] MAX_RC = 2'(GRID_DIM - 1);

    logic [4:0] w_raw;
    logic [4:0] w_pulse;
    logic [3:0] w_dir;
    logic [1:0] w_row_nxt;
    logic [1:0] w_col_nxt;
    logic       w_moved;
    logic [1:0] r_row;
    logic [1:0] r_col;
    logic       r_move;

    // Bit order: 4 up, 3 down, 2 left, 1 right, 0 start.
    assign w_raw = {btn_up, btn_down, btn_left, btn_right, btn_start};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond (
            .clk   (clk),
            .rst   (rst),
            .raw   (w_raw[i]),
            .level (),
            .pulse (w_pulse[i])
        );
    end

    assign w_dir = w_pulse[4:1];

    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        w_moved   = 1'b0;
        case (game_state)
            GS_INIT: begin
                w_row_nxt = 2'd1;
                w_col_nxt = 2'd1;
            end
            GS_PLAY: begin
                // Simultaneous directions are ambiguous, so only a lone pulse moves the player.
                if ($onehot(w_dir)) begin
                    if (w_dir[3] && r_row != 2'd0)   w_row_nxt = r_row - 2'd1;
                    if (w_dir[2] && r_row != MAX_RC) w_row_nxt = r_row + 2'd1;
                    if (w_dir[1] && r_col != 2'd0)   w_col_nxt = r_col - 2'd1;
                    if (w_dir[0] && r_col != MAX_RC) w_col_nxt = r_col + 2'd1;
                end
                w_moved = (w_row_nxt != r_row) || (w_col_nxt != r_col);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row  <= 2'd1;
            r_col  <= 2'd1;
            r_move <= 1'b0;
        end else begin
            r_row  <= w_row_nxt;
            r_col  <= w_col_nxt;
            r_move <= w_moved;
        end
    end

    assign box        = rc_to_box(r_row, r_col);
    assign start_op   = w_pulse[0];
    assign move_pulse = r_move;

endmodule

// File: tb/tb_player_input.sv
// Directed bench for player_input with a short debounce window (DB_CYCLES=4).
// A press applied just after edge k is sampled at edge k+1 (edge 0): pulse visible after edge 6, move after edge 7.
module tb_player_input;
    import game_pkg::*;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_start;
    logic [1:0] game_state;
    logic [8:0] box;
    logic       start_op;
    logic       move_pulse;

    int         vec_cnt  = 0;
    int         fail_cnt = 0;
    logic [8:0] exp_box;

    player_input #(.DB_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_start  (btn_start),
        .game_state (game_state),
        .box        (box),
        .start_op   (start_op),
        .move_pulse (move_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        vec_cnt++;
        assert (got === exp) else begin
            fail_cnt++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic set_dirs(input logic [3:0] d);
        {btn_up, btn_down, btn_left, btn_right} = d;
    endtask

    // Hold direction buttons d for 10 cycles, then release for 8; the move lands after tick 8.
    task automatic press_dir(input string tag, input logic [3:0] d,
                             input logic [8:0] new_box, input logic mv);
        set_dirs(d);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("%s box t%0d", tag, k), box, (k >= 8) ? new_box : exp_box);
            check($sformatf("%s mv t%0d", tag, k), {8'b0, move_pulse}, {8'b0, (k == 8) && mv});
        end
        exp_box = new_box;
        set_dirs(4'b0000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("%s rel box t%0d", tag, k), box, exp_box);
            check($sformatf("%s rel mv t%0d", tag, k), {8'b0, move_pulse}, 9'b0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        game_state = GS_INIT;
        btn_start  = 1'b0;
        set_dirs(4'b0000);
        tick();
        tick();
        check("rst box", box, 9'b000010000);
        check("rst start", {8'b0, start_op}, 9'b0);
        check("rst mv", {8'b0, move_pulse}, 9'b0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("idle box", box, 9'b000010000);
            check("idle start", {8'b0, start_op}, 9'b0);
            check("idle mv", {8'b0, move_pulse}, 9'b0);
        end

        // Held start: exactly one pulse, after edge 6 (tick 7).
        btn_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("start hold t%0d", k), {8'b0, start_op}, {8'b0, k == 7});
        end
        btn_start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("start release", {8'b0, start_op}, 9'b0);
        end

        // Three-cycle glitch is shorter than the debounce window.
        btn_start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("glitch hi", {8'b0, start_op}, 9'b0);
        end
        btn_start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("glitch lo", {8'b0, start_op}, 9'b0);
        end

        game_state = GS_PLAY;
        exp_box    = 9'b000010000;
        press_dir("up1", 4'b1000, 9'b000000010, 1'b1);
        press_dir("up2 clamp", 4'b1000, 9'b000000010, 1'b0);

        game_state = GS_INIT;
        tick();
        check("init recentre", box, 9'b000010000);
        check("init mv", {8'b0, move_pulse}, 9'b0);
        exp_box    = 9'b000010000;
        game_state = GS_PLAY;

        press_dir("right1", 4'b0001, 9'b000100000, 1'b1);
        press_dir("right2 clamp", 4'b0001, 9'b000100000, 1'b0);
        press_dir("down1", 4'b0100, 9'b100000000, 1'b1);
        press_dir("down2 clamp", 4'b0100, 9'b100000000, 1'b0);
        press_dir("left+up", 4'b1010, 9'b100000000, 1'b0);

        game_state = GS_FINISH;
        press_dir("finish left", 4'b0010, 9'b100000000, 1'b0);
        game_state = 2'b11;
        press_dir("gs11 up", 4'b1000, 9'b100000000, 1'b0);

        game_state = GS_INIT;
        tick();
        check("init2 recentre", box, 9'b000010000);
        exp_box    = 9'b000010000;
        game_state = GS_PLAY;
        press_dir("right pre-rst", 4'b0001, 9'b000100000, 1'b1);

        // Reset in the middle of a down debounce; the held button re-qualifies from scratch.
        btn_down = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("down pre-rst box", box, 9'b000100000);
        end
        rst = 1'b1;
        #1;
        check("async rst box", box, 9'b000010000);
        check("async rst mv", {8'b0, move_pulse}, 9'b0);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("post-rst box t%0d", k), box, (k >= 8) ? 9'b010000000 : 9'b000010000);
            check($sformatf("post-rst mv t%0d", k), {8'b0, move_pulse}, {8'b0, k == 8});
        end
        btn_down = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("final box", box, 9'b010000000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
